// File: rtl/softmax_pkg.sv
// Shared defaults, index-width helper and FSM encoding for the softmax result decoder.
package softmax_pkg;

    localparam int DEF_NUM_INPUTS = 4;
    localparam int DEF_EXP_WIDTH  = 4;
    localparam int DEF_MANT_WIDTH = 3;
    localparam int DEF_OUT_WIDTH  = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    // Element index width; a single-element result still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/softmax_result_decoder_prob_shifter.sv
// Converts a shared mantissa and one element exponent into a fixed-point probability.
module prob_shifter #(
    parameter int EXP_WIDTH  = 4,
    parameter int MANT_WIDTH = 3,
    parameter int OUT_WIDTH  = 8
) (
    input  logic [MANT_WIDTH-1:0] mant,
    input  logic [EXP_WIDTH-1:0]  exp_val,
    output logic [OUT_WIDTH-1:0]  prob
);

    logic [OUT_WIDTH-1:0] aligned;

    // Hidden one plus mantissa sits at the top (value in [0.5,1)), then shifts down; bits falling off are truncated.
    always_comb begin
        aligned = '0;
        aligned[OUT_WIDTH-1 -: MANT_WIDTH+1] = {1'b1, mant};
        if (32'(exp_val) >= OUT_WIDTH) begin
            prob = '0;
        end else begin
            prob = aligned >> exp_val;
        end
    end

endmodule

// File: rtl/softmax_result_decoder.sv
// Captures one softmax result (shared mantissa + per-element exponents) and streams
// each element's fixed-point probability in index order; also reports the argmax.
module softmax_result_decoder
    import softmax_pkg::*;
#(
    parameter int   NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int   EXP_WIDTH  = DEF_EXP_WIDTH,
    parameter int   MANT_WIDTH = DEF_MANT_WIDTH,
    parameter int   OUT_WIDTH  = DEF_OUT_WIDTH,
    localparam int  IDX_WIDTH  = idx_width(NUM_INPUTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [MANT_WIDTH-1:0]           mant_in,
    input  logic [NUM_INPUTS*EXP_WIDTH-1:0] exp_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_WIDTH-1:0]            out_data,
    output logic [IDX_WIDTH-1:0]            out_index,
    output logic                            out_last,
    output logic                            argmax_valid,
    output logic [IDX_WIDTH-1:0]            argmax_index
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_INPUTS - 1);

    state_e                                state_q, state_d;
    logic [IDX_WIDTH-1:0]                  cnt_q, cnt_d;
    logic [MANT_WIDTH-1:0]                 mant_q, mant_d;
    logic [NUM_INPUTS-1:0][EXP_WIDTH-1:0]  exp_q, exp_d;
    logic                                  argmax_valid_q, argmax_valid_d;
    logic [IDX_WIDTH-1:0]                  argmax_q, argmax_d;

    logic [IDX_WIDTH-1:0]                  best_idx;
    logic [EXP_WIDTH-1:0]                  best_exp;
    logic [EXP_WIDTH-1:0]                  cur_exp;
    logic [OUT_WIDTH-1:0]                  cur_prob;
    logic                                  streaming;

    // Smallest exponent wins; strict compare keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_exp = exp_in[0 +: EXP_WIDTH];
        for (int i = 1; i < NUM_INPUTS; i++) begin
            if (exp_in[i*EXP_WIDTH +: EXP_WIDTH] < best_exp) begin
                best_exp = exp_in[i*EXP_WIDTH +: EXP_WIDTH];
                best_idx = IDX_WIDTH'(i);
            end
        end
    end

    assign cur_exp = exp_q[cnt_q];

    prob_shifter #(
        .EXP_WIDTH  (EXP_WIDTH),
        .MANT_WIDTH (MANT_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH)
    ) u_prob_shifter (
        .mant    (mant_q),
        .exp_val (cur_exp),
        .prob    (cur_prob)
    );

    // Next-state: capture in IDLE, advance on each accepted element, return to IDLE after the last.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mant_d         = mant_q;
        exp_d          = exp_q;
        argmax_valid_d = argmax_valid_q;
        argmax_d       = argmax_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mant_d         = mant_in;
                    exp_d          = exp_in;
                    cnt_d          = '0;
                    argmax_d       = best_idx;
                    argmax_valid_d = 1'b1;
                    state_d        = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (out_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and capture registers; reset overrides any capture or handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            mant_q         <= '0;
            exp_q          <= '0;
            argmax_valid_q <= 1'b0;
            argmax_q       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mant_q         <= mant_d;
            exp_q          <= exp_d;
            argmax_valid_q <= argmax_valid_d;
            argmax_q       <= argmax_d;
        end
    end

    // Element outputs are zeroed outside a stream so idle/reset shows all-zero data.
    always_comb begin
        streaming = (state_q == ST_STREAM);
        in_ready  = (state_q == ST_IDLE);
        out_valid = streaming;
        out_data  = streaming ? cur_prob : '0;
        out_index = streaming ? cnt_q : '0;
        out_last  = streaming && (cnt_q == LAST_IDX);
    end

    assign argmax_valid = argmax_valid_q;
    assign argmax_index = argmax_q;

endmodule

// File: tb/tb_softmax_result_decoder.sv
// Directed bench for softmax_result_decoder at default parameters (4 elements, 4/3/8 widths).
module tb_softmax_result_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  mant_in;
    logic [15:0] exp_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_index;
    logic        out_last;
    logic        argmax_valid;
    logic [1:0]  argmax_index;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    softmax_result_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mant_in      (mant_in),
        .exp_in       (exp_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_last     (out_last),
        .argmax_valid (argmax_valid),
        .argmax_index (argmax_index)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        mant_in = 3'b101; exp_in = 16'h1234;
        tick; tick;
        vec_cnt++;
        if ({out_valid, in_ready, out_data, out_index, out_last, argmax_valid, argmax_index} !==
            {1'b0, 1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 2'd0}) begin
            miss_cnt++;
            $display("FAIL reset_hold: valid=%b rdy=%b data=%h idx=%0d last=%b amv=%b ami=%0d",
                     out_valid, in_ready, out_data, out_index, out_last, argmax_valid, argmax_index);
        end
        rst = 1'b0; in_valid = 1'b0;
        tick;
        vec_cnt++;
        if ({out_valid, in_ready, argmax_valid} !== 3'b010) begin
            miss_cnt++;
            $display("FAIL reset_idle: valid=%b rdy=%b amv=%b want 0 1 0", out_valid, in_ready, argmax_valid);
        end
    endtask

    task automatic test_basic;
        logic [7:0] want [4];
        want[0] = 8'hC0; want[1] = 8'h60; want[2] = 8'h30; want[3] = 8'h00;
        mant_in = 3'b100; exp_in = {4'd9, 4'd2, 4'd1, 4'd0};
        out_ready = 1'b1; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        vec_cnt++;
        if ({argmax_valid, argmax_index} !== {1'b1, 2'd0}) begin
            miss_cnt++;
            $display("FAIL basic_argmax: got v=%b i=%0d want v=1 i=0", argmax_valid, argmax_index);
        end
        for (int k = 0; k < 4; k++) begin
            vec_cnt++;
            if ({out_valid, in_ready, out_index, out_last, out_data} !==
                {1'b1, 1'b0, 2'(k), (k == 3), want[k]}) begin
                miss_cnt++;
                $display("FAIL basic_elem[%0d]: got v=%b r=%b i=%0d l=%b d=%h want d=%h",
                         k, out_valid, in_ready, out_index, out_last, out_data, want[k]);
            end
            tick;
        end
        vec_cnt++;
        if ({out_valid, in_ready, out_data, out_index, out_last} !== {1'b0, 1'b1, 8'h00, 2'd0, 1'b0}) begin
            miss_cnt++;
            $display("FAIL basic_done: got v=%b r=%b d=%h want idle", out_valid, in_ready, out_data);
        end
    endtask

    task automatic test_tie;
        logic [7:0] want [4];
        want[0] = 8'h01; want[1] = 8'h00; want[2] = 8'h10; want[3] = 8'h10;
        mant_in = 3'b000; exp_in = {4'd3, 4'd3, 4'd8, 4'd7};
        out_ready = 1'b1; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        vec_cnt++;
        if ({argmax_valid, argmax_index} !== {1'b1, 2'd2}) begin
            miss_cnt++;
            $display("FAIL tie_argmax: got v=%b i=%0d want v=1 i=2", argmax_valid, argmax_index);
        end
        for (int k = 0; k < 4; k++) begin
            vec_cnt++;
            if ({out_valid, out_index, out_last, out_data} !== {1'b1, 2'(k), (k == 3), want[k]}) begin
                miss_cnt++;
                $display("FAIL tie_elem[%0d]: got v=%b i=%0d l=%b d=%h want d=%h",
                         k, out_valid, out_index, out_last, out_data, want[k]);
            end
            tick;
        end
    endtask

    task automatic test_stall;
        logic [7:0] want [4];
        logic       pat  [8];
        int         k;
        want[0] = 8'h05; want[1] = 8'h14; want[2] = 8'h0A; want[3] = 8'h14;
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        pat[4] = 1; pat[5] = 1; pat[6] = 1; pat[7] = 1;
        mant_in = 3'b010; exp_in = {4'd3, 4'd4, 4'd3, 4'd5};
        out_ready = 1'b1; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        vec_cnt++;
        if (argmax_index !== 2'd1) begin
            miss_cnt++;
            $display("FAIL stall_argmax: got %0d want 1", argmax_index);
        end
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            out_ready = (c < 8) ? pat[c] : 1'b1;
            vec_cnt++;
            if ({out_valid, out_index, out_last, out_data} !== {1'b1, 2'(k), (k == 3), want[k]}) begin
                miss_cnt++;
                $display("FAIL stall_cyc[%0d]: got v=%b i=%0d l=%b d=%h want i=%0d d=%h",
                         c, out_valid, out_index, out_last, out_data, k, want[k]);
            end
            if (out_ready) k++;
            tick;
        end
        out_ready = 1'b1;
        vec_cnt++;
        if (k !== 4 || out_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL stall_end: accepted %0d valid=%b want 4 and 0", k, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] want_a [4];
        logic [7:0] want_b [4];
        want_a[0] = 8'hF0; want_a[1] = 8'h0F; want_a[2] = 8'h00; want_a[3] = 8'h00;
        want_b[0] = 8'h02; want_b[1] = 8'h24; want_b[2] = 8'h48; want_b[3] = 8'h01;
        mant_in = 3'b111; exp_in = {4'd15, 4'd8, 4'd4, 4'd0};
        out_ready = 1'b1; in_valid = 1'b1;
        tick;
        // Present the second result immediately; it must not disturb the stream in flight.
        mant_in = 3'b001; exp_in = {4'd7, 4'd1, 4'd2, 4'd6};
        vec_cnt++;
        if (argmax_index !== 2'd0) begin
            miss_cnt++;
            $display("FAIL b2b_argmax_a: got %0d want 0", argmax_index);
        end
        for (int k = 0; k < 4; k++) begin
            vec_cnt++;
            if ({out_valid, in_ready, out_index, out_last, out_data} !==
                {1'b1, 1'b0, 2'(k), (k == 3), want_a[k]}) begin
                miss_cnt++;
                $display("FAIL b2b_a[%0d]: got v=%b r=%b i=%0d l=%b d=%h want d=%h",
                         k, out_valid, in_ready, out_index, out_last, out_data, want_a[k]);
            end
            tick;
        end
        vec_cnt++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miss_cnt++;
            $display("FAIL b2b_gap: got v=%b r=%b want 0 1", out_valid, in_ready);
        end
        tick;
        in_valid = 1'b0;
        vec_cnt++;
        if ({argmax_valid, argmax_index} !== {1'b1, 2'd2}) begin
            miss_cnt++;
            $display("FAIL b2b_argmax_b: got v=%b i=%0d want v=1 i=2", argmax_valid, argmax_index);
        end
        for (int k = 0; k < 4; k++) begin
            vec_cnt++;
            if ({out_valid, out_index, out_last, out_data} !== {1'b1, 2'(k), (k == 3), want_b[k]}) begin
                miss_cnt++;
                $display("FAIL b2b_b[%0d]: got v=%b i=%0d l=%b d=%h want d=%h",
                         k, out_valid, out_index, out_last, out_data, want_b[k]);
            end
            tick;
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] want [4];
        want[0] = 8'h38; want[1] = 8'h38; want[2] = 8'hE0; want[3] = 8'h70;
        mant_in = 3'b011; exp_in = {4'd6, 4'd5, 4'd1, 4'd3};
        out_ready = 1'b1; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        vec_cnt++;
        if ({argmax_index, out_data} !== {2'd1, 8'h16}) begin
            miss_cnt++;
            $display("FAIL rmid_e0: got ami=%0d d=%h want 1 16", argmax_index, out_data);
        end
        tick;
        vec_cnt++;
        if ({out_valid, out_index, out_data} !== {1'b1, 2'd1, 8'h58}) begin
            miss_cnt++;
            $display("FAIL rmid_e1: got v=%b i=%0d d=%h want 1 1 58", out_valid, out_index, out_data);
        end
        // Reset lands together with an accepted handshake.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        vec_cnt++;
        if ({out_valid, in_ready, out_data, out_index, out_last, argmax_valid, argmax_index} !==
            {1'b0, 1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 2'd0}) begin
            miss_cnt++;
            $display("FAIL rmid_reset: v=%b r=%b d=%h i=%0d l=%b amv=%b ami=%0d",
                     out_valid, in_ready, out_data, out_index, out_last, argmax_valid, argmax_index);
        end
        mant_in = 3'b110; exp_in = {4'd1, 4'd0, 4'd2, 4'd2};
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        vec_cnt++;
        if ({argmax_valid, argmax_index} !== {1'b1, 2'd2}) begin
            miss_cnt++;
            $display("FAIL rmid_argmax: got v=%b i=%0d want v=1 i=2", argmax_valid, argmax_index);
        end
        for (int k = 0; k < 4; k++) begin
            vec_cnt++;
            if ({out_valid, out_index, out_last, out_data} !== {1'b1, 2'(k), (k == 3), want[k]}) begin
                miss_cnt++;
                $display("FAIL rmid_elem[%0d]: got v=%b i=%0d l=%b d=%h want d=%h",
                         k, out_valid, out_index, out_last, out_data, want[k]);
            end
            tick;
        end
        vec_cnt++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miss_cnt++;
            $display("FAIL rmid_done: got v=%b r=%b want 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        mant_in = '0; exp_in = '0;
        test_reset;
        test_basic;
        test_tie;
        test_stall;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/softmax_result_decoder.md
SOFTMAX_RESULT_DECODER -- requirements
Module: softmax_result_decoder

Interface
REQ-001 Parameter NUM_INPUTS, default 4: number of softmax elements per result.
REQ-002 Parameter EXP_WIDTH, default 4: per-element exponent width.
REQ-003 Parameter MANT_WIDTH, default 3: shared mantissa width.
REQ-004 Parameter OUT_WIDTH, default 8: fixed-point probability width, all bits fractional; OUT_WIDTH >= MANT_WIDTH+1.
REQ-005 Derived constant IDX_WIDTH = max(1, clog2(NUM_INPUTS)).
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 in_valid  input  1  producer offers a softmax result.
REQ-010 in_ready  output  1  decoder can capture a result.
REQ-011 mant_in  input  MANT_WIDTH  shared mantissa of the result.
REQ-012 exp_in  input  NUM_INPUTS*EXP_WIDTH  per-element exponents; element i at bits [i*EXP_WIDTH +: EXP_WIDTH].
REQ-013 out_valid  output  1  out_data/out_index/out_last valid.
REQ-014 out_ready  input  1  consumer accepts the current element.
REQ-015 out_data  output  OUT_WIDTH  fixed-point probability of the current element.
REQ-016 out_index  output  IDX_WIDTH  index of the current element.
REQ-017 out_last  output  1  current element is index NUM_INPUTS-1.
REQ-018 argmax_valid  output  1  argmax_index holds a result.
REQ-019 argmax_index  output  IDX_WIDTH  index of the largest-probability element.

Function
REQ-020 FSM states: IDLE, STREAM.
REQ-021 in_ready is 1 in IDLE and 0 in STREAM.
REQ-022 Capture occurs on clk edge with in_valid && in_ready: mant_in and exp_in are registered, the element counter is cleared to 0, and the state becomes STREAM.
REQ-023 out_valid is 1 exactly while in STREAM; element 0 is presented the cycle after capture (latency 1).
REQ-024 out_data, out_index, out_last hold stable while out_valid && !out_ready.
REQ-025 On out_valid && out_ready, the counter increments; if out_last, the state returns to IDLE instead.
REQ-026 Elements stream in ascending index order, each exactly once per capture.
REQ-027 Conversion: {1'b1, mant} is placed MSB-aligned at out_data bit OUT_WIDTH-1 (value in [0.5,1)), zero-filled below, then logically right-shifted by the element exponent.
REQ-028 Exponent >= OUT_WIDTH yields out_data = 0; truncation only, no rounding.
REQ-029 argmax: the element with the smallest exponent; ties resolve to the lowest index.
REQ-030 argmax_index is registered at capture and holds until the next capture; argmax_valid rises the cycle after the first capture and stays 1.
REQ-031 NUM_INPUTS = 1: single element with out_last = 1, argmax_index = 0.
REQ-032 in_valid in STREAM is ignored; inputs are not sampled.

Reset
REQ-033 When rst is sampled high: state = IDLE, counter = 0, captured registers = 0, out_valid = 0, out_data = 0, out_index = 0, out_last = 0, argmax_valid = 0, argmax_index = 0; in_ready = 1 the cycle after reset.
REQ-034 Reset mid-stream aborts the stream; remaining elements are discarded.
REQ-035 Reset has priority over a simultaneous capture or out handshake.

Structure
REQ-036 Shared package softmax_pkg holds the default widths, IDX_WIDTH computation and FSM state encoding.
REQ-037 One combinational sub-module prob_shifter performs the REQ-027/028 conversion.

Verification (NUM_INPUTS=4, EXP_WIDTH=4, MANT_WIDTH=3, OUT_WIDTH=8)
REQ-038 mant=3'b100, exps {0,1,2,9}, out_ready=1 -> out_data 0xC0,0x60,0x30,0x00 on 4 consecutive cycles, out_last on the 4th, argmax_index=0.
REQ-039 mant=3'b000, exps {7,8,3,3} -> out_data 0x01,0x00,0x10,0x10; argmax_index=2 (tie goes to the lower index).
REQ-040 out_ready toggling 1,0,0,1 during a stream -> outputs hold during stalls, no element skipped or duplicated.
REQ-041 in_valid held high through a stream -> in_ready=0 throughout; the second result is captured the cycle after the last handshake, with its first element one cycle later.
REQ-042 rst asserted after element 1 -> the next cycle shows out_valid=0, all outputs 0 and in_ready=1; a new capture streams from index 0.
